multi_clk_divider: RTL
======================

MULTI_CLK_DIVIDER -- requirements
Module: multi_clk_divider

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16: divisor and counter width.
REQ-003 SHALL have parameter DEF_DIV, default 2: divisor loaded into every channel at reset (2..2^CNT_W-1).
REQ-004 SHALL have port clk  in  1  single system clock; all logic on posedge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port en  in  1  global count enable.
REQ-007 SHALL have port cfg_valid  in  1  divisor write request.
REQ-008 SHALL have port cfg_ready  out  1  write accepted when cfg_valid && cfg_ready.
REQ-009 SHALL have port cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
REQ-010 SHALL have port cfg_div  in  CNT_W  requested divisor.
REQ-011 SHALL have port cfg_err  out  1  one-cycle pulse: write rejected.
REQ-012 SHALL have port tick  out  NUM_CH  per-channel one-cycle pulse, once per period.
REQ-013 SHALL have port clk_out  out  NUM_CH  per-channel divided square wave.

Function
REQ-014 Per channel SHALL hold count (CNT_W), active divisor D, shadow divisor and pending flag.
REQ-015 With en=1 count SHALL step 0,1,..,D-1,0; with en=0 count, clk_out and pending SHALL hold and tick SHALL be 0.
REQ-016 tick[i] SHALL be registered and high exactly in the cycle after the edge where count goes D-1 -> 0; period D cycles.
REQ-017 clk_out[i] SHALL be registered, high while count < ceil(D/2), else low (odd D: high one cycle longer).
REQ-018 cfg_ready SHALL be combinational: 1 unless pending[cfg_ch]=1 or cfg_ch >= NUM_CH.
REQ-019 Accepted write with 2 <= cfg_div SHALL store shadow, set pending; active D unchanged.
REQ-020 Accepted write with cfg_div < 2 SHALL pulse cfg_err next cycle and leave shadow/pending unchanged.
REQ-021 Pending shadow SHALL become active D at the D-1 -> 0 transition, so the next period uses the new divisor; pending clears same edge.
REQ-022 No partial period: tick and clk_out SHALL never show a period shorter than min(old D, new D).
REQ-023 Write to channel i SHALL NOT affect count or phase of any other channel.

Reset
REQ-024 rst_n=0 at posedge SHALL set count=0, D=DEF_DIV, pending=0, tick=0, clk_out=0, cfg_err=0; cfg_ready=1 after release.
REQ-025 Reset mid-period or with pending update SHALL discard the pending value; no tick is emitted during or on release.

Configuration
REQ-026 Macro DIV_ALIGN_EN defined: adds input align (1 bit); align=1 SHALL zero all counts, apply all pending shadows, clear pending, force tick=0, independent of en; takes priority over terminal-count update.
REQ-027 A write accepted in the same cycle as align SHALL stay pending and apply at the next terminal count.
REQ-028 DIV_ALIGN_EN undefined: align port and logic absent; all other behaviour identical.

Structure
REQ-029 Package div_pkg SHALL hold CNT_W default, DIV_MIN=2 constant and typedef div_t (logic [CNT_W-1:0]).
REQ-030 Sub-module div_channel SHALL implement one channel (counter, shadow, pending, tick, clk_out); top instantiates NUM_CH via generate and owns cfg decode.

Verification
REQ-031 Reset, en=1, defaults: tick every 2 cycles, clk_out 1,0,1,0 on all channels.
REQ-032 Write ch1 D=5 mid-period: old period completes, then tick every 5 cycles, clk_out 3 high/2 low; ch0/2/3 unchanged.
REQ-033 Write cfg_div=1 and 0: cfg_err pulses one cycle each, divisor unchanged; second write to pending channel sees cfg_ready=0.
REQ-034 en low for 7 cycles mid-period: no tick, count/clk_out frozen, resume with correct remaining count.
REQ-035 rst_n low with pending ch2 update to 9: after release ch2 runs at DEF_DIV.
REQ-036 DIV_ALIGN_EN: channels D=3,4 drifted; align pulse -> both restart at count 0 same cycle, ticks coincide every 12 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared constants and types for multi_clk_divider.
package div_pkg;
    localparam int CNT_W_DEF = 16;
    localparam int DIV_MIN   = 2;
    typedef logic [CNT_W_DEF-1:0] div_t;
endpackage

// File: rtl/div_channel.sv
// div_channel: one divider channel (counter, shadowed divisor, tick, square wave).
// Defining DIV_ALIGN_EN adds the align input that restarts the channel at count 0.
module div_channel
    import div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DIV_MIN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
`ifdef DIV_ALIGN_EN
    input  logic             align,
`endif
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pending,
    output logic             tick,
    output logic             clk_out
);
    logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d;
    logic             pend_q, pend_d, tick_q, tick_d, clk_q, clk_d, last, algn;
    logic [CNT_W:0]   half;

    always_comb begin
`ifdef DIV_ALIGN_EN
        algn = align;
`else
        algn = 1'b0;
`endif
        last     = cnt_q == div_q - 1'b1;
        cnt_d    = cnt_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        tick_d   = 1'b0;
        clk_d    = clk_q;
        // a period boundary is the only point where a new divisor may take over
        if (algn || (en && last)) begin
            cnt_d  = '0;
            tick_d = !algn;
            div_d  = pend_q ? shadow_q : div_q;
            pend_d = 1'b0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (wr) begin
            shadow_d = wr_div;
            pend_d   = 1'b1;
        end
        half = ({1'b0, div_d} + 1'b1) >> 1;
        if (algn || en) clk_d = {1'b0, cnt_d} < half;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            div_q    <= CNT_W'(DEF_DIV);
            shadow_q <= CNT_W'(DEF_DIV);
            pend_q   <= 1'b0;
            tick_q   <= 1'b0;
            clk_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            clk_q    <= clk_d;
        end
    end

    assign pending = pend_q;
    assign tick    = tick_q;
    assign clk_out = clk_q;
endmodule

// File: rtl/multi_clk_divider.sv
// multi_clk_divider: NUM_CH independent clock dividers with a shared divisor write port.
// Defining DIV_ALIGN_EN adds the align input that restarts all channels together.
module multi_clk_divider
    import div_pkg::*;
#(
    parameter int  NUM_CH  = 4,
    parameter int  CNT_W   = CNT_W_DEF,
    parameter int  DEF_DIV = DIV_MIN,
    localparam int CH_W    = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
`ifdef DIV_ALIGN_EN
    input  logic              align,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);
    logic [NUM_CH-1:0]    pend;
    logic [2**CH_W-1:0]   busy;
    logic                 accept, div_ok, cfg_err_q, cfg_err_d;

    // channel indices past NUM_CH read as permanently busy, so they are never accepted
    always_comb begin
        busy               = '1;
        busy[NUM_CH-1:0]   = pend;
        cfg_ready          = !busy[cfg_ch];
        accept             = cfg_valid && cfg_ready;
        div_ok             = cfg_div >= CNT_W'(DIV_MIN);
        cfg_err_d          = accept && !div_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cfg_err_q <= 1'b0;
        else        cfg_err_q <= cfg_err_d;
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        div_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
`ifdef DIV_ALIGN_EN
            .align   (align),
`endif
            .wr      (accept && div_ok && cfg_ch == CH_W'(i)),
            .wr_div  (cfg_div),
            .pending (pend[i]),
            .tick    (tick[i]),
            .clk_out (clk_out[i])
        );
    end
endmodule
